// File: rtl/div_unit_pkg.sv
// Shared constants for the iterative divider: FSM encodings, handshake levels,
// and an absolute-value helper used when latching signed operands.
package div_unit_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] DIV_FREE    = 2'b00;
  localparam logic [1:0] DIV_BY_ZERO = 2'b01;
  localparam logic [1:0] DIV_ON      = 2'b10;
  localparam logic [1:0] DIV_END     = 2'b11;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  localparam logic [WORD_W-1:0] ZERO_WORD = '0;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is still the
  // correct unsigned magnitude.
  function automatic logic [WORD_W-1:0] abs_word(input logic [WORD_W-1:0] v);
    return v[WORD_W-1] ? (ZERO_WORD - v) : v;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Handshake/data bundle between the execute stage (master) and the divider (slave).
interface div_unit_if #(parameter int DATA_W = 32);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring divider: one quotient bit per cycle, MSB first, on
// operand magnitudes, with sign correction applied when the result is registered.
// result_o = {remainder, quotient}; all outputs come straight from flops.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic     clk,
  input  logic     rst,
  div_unit_if.slave d
);

  logic [1:0]          state;
  logic [5:0]          cnt;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   quo;    // holds the dividend, shifted out as quotient bits shift in
  logic [DATA_W-1:0]   dvsr;
  logic                neg_q;
  logic                neg_r;
  logic [2*DATA_W-1:0] result_q;
  logic                ready_q;

  logic [DATA_W:0]     partial;
  logic [DATA_W:0]     diff;
  logic [DATA_W-1:0]   q_fix;
  logic [DATA_W-1:0]   r_fix;

  // Trial subtract: rem < dvsr always holds, so a non-negative difference fits
  // in DATA_W bits and the top bit of the 33-bit result is a clean borrow.
  always_comb begin
    partial = {rem, quo[DATA_W-1]};
    diff    = partial - {1'b0, dvsr};
    q_fix   = neg_q ? (ZERO_WORD - quo) : quo;
    r_fix   = neg_r ? (ZERO_WORD - rem) : rem;
  end

  // Divider FSM and datapath; annul outranks an iteration, rst outranks everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= '0;
      ready_q  <= DIV_RESULT_NOT_READY;
    end else begin
      case (state)
        DIV_FREE: begin
          if (d.start_i == DIV_START && !d.annul_i) begin
            state <= (d.opdata2_i == ZERO_WORD) ? DIV_BY_ZERO : DIV_ON;
            cnt   <= '0;
            rem   <= '0;
            quo   <= d.signed_div_i ? abs_word(d.opdata1_i) : d.opdata1_i;
            dvsr  <= d.signed_div_i ? abs_word(d.opdata2_i) : d.opdata2_i;
            neg_q <= d.signed_div_i & (d.opdata1_i[DATA_W-1] ^ d.opdata2_i[DATA_W-1]);
            neg_r <= d.signed_div_i & d.opdata1_i[DATA_W-1];
          end
        end
        DIV_BY_ZERO: begin
          if (d.annul_i) begin
            state <= DIV_FREE;
          end else begin
            state    <= DIV_END;
            result_q <= '0;
            ready_q  <= DIV_RESULT_READY;
          end
        end
        DIV_ON: begin
          if (d.annul_i) begin
            state <= DIV_FREE;
          end else if (cnt != 6'd32) begin
            if (diff[DATA_W]) begin
              rem <= partial[DATA_W-1:0];
              quo <= {quo[DATA_W-2:0], 1'b0};
            end else begin
              rem <= diff[DATA_W-1:0];
              quo <= {quo[DATA_W-2:0], 1'b1};
            end
            cnt <= cnt + 6'd1;
          end else begin
            state    <= DIV_END;
            result_q <= {r_fix, q_fix};
            ready_q  <= DIV_RESULT_READY;
          end
        end
        DIV_END: begin
          if (d.start_i == DIV_STOP) begin
            state    <= DIV_FREE;
            result_q <= '0;
            ready_q  <= DIV_RESULT_NOT_READY;
          end
        end
        default: state <= DIV_FREE;
      endcase
    end
  end

  assign d.result_o = result_q;
  assign d.ready_o  = ready_q;

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i.
REQ-005 SHALL have port opdata1_i  input  32  dividend; sampled with start_i.
REQ-006 SHALL have port opdata2_i  input  32  divisor; sampled with start_i.
REQ-007 SHALL have port start_i  input  1  request from ex; held high by ex until the result is consumed.
REQ-008 SHALL have port annul_i  input  1  abort current division, for a pipeline flush.
REQ-009 SHALL have port result_o  output  64  {remainder[63:32] -> hi, quotient[31:0] -> lo}.
REQ-010 SHALL have port ready_o  output  1  result_o valid.

Function
REQ-011 SHALL implement FSM states DivFree, DivByZero, DivOn, DivEnd.
REQ-012 SHALL, in DivFree with start_i=1 and annul_i=0: enter DivByZero if opdata2_i==0, else enter DivOn.
REQ-013 SHALL, when entering DivOn, latch the absolute values of the operands when signed_div_i=1, otherwise the raw values.
REQ-014 SHALL also latch the sign flags and clear the iteration counter when entering DivOn.
REQ-015 SHALL perform one restoring shift-subtract step per cycle in DivOn, producing 1 quotient bit per cycle, MSB first.
REQ-016 SHALL use a 33-bit subtract so the borrow determines the quotient bit.
REQ-017 SHALL leave DivOn after exactly 32 iterations and, on the same edge, register result_o and enter DivEnd.
REQ-018 SHALL make ready_o=1 in the cycle after edge 33, counting the edge that sampled start_i as edge 0.
REQ-019 SHALL apply signed correction: quotient negated if the operand signs differ; remainder takes the dividend's sign.
REQ-020 SHALL return quotient 0x80000000 and remainder 0 for signed 0x80000000 / 0xFFFFFFFF (wraps, no trap).
REQ-021 SHALL, in DivByZero, enter DivEnd on the next edge with result_o=0; ready_o is then high 2 edges after start.
REQ-022 SHALL, in DivEnd, hold ready_o=1 and result_o stable while start_i=1.
REQ-023 SHALL, in DivEnd with start_i=0, enter DivFree and drive ready_o=0 and result_o=0 on the next edge.
REQ-024 SHALL, when annul_i=1 in DivOn or DivByZero, enter DivFree on the next edge and never raise ready_o for that request.
REQ-025 SHALL give annul_i priority over a simultaneous iteration step.
REQ-026 SHALL ignore operand changes while in DivOn, DivByZero or DivEnd; only the latched copies are used.
REQ-027 SHALL accept a new start_i on the first cycle back in DivFree.
REQ-028 SHALL keep ready_o=0 in every state other than DivEnd.

Reset
REQ-029 SHALL, when rst=1 at a clock edge, set state=DivFree, ready_o=0, result_o=0, iteration counter=0 and clear the working registers.
REQ-030 SHALL give rst priority over start_i and annul_i and abort any division in progress.

Structure
REQ-031 SHALL take the state encodings and the macros DivResultReady/NotReady, DivStart/Stop, ZeroWord and Reg from the shared define.v.
REQ-032 SHALL be a single module with no sub-module.
REQ-033 SHALL have a registered output path only; there is no combinational path from inputs to outputs.

Verification
REQ-034 SHALL verify unsigned 100/7 -> result_o={32'd2,32'd14}, ready_o rises exactly 34 cycles after start.
REQ-035 SHALL verify signed -7/2 (0xFFFFFFF9/0x2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; the unsigned case with the same operands -> quotient 0x7FFFFFFC, remainder 1.
REQ-036 SHALL verify 5/0 -> result_o=0, ready_o high 2 cycles after start; signed 0x80000000/0xFFFFFFFF -> {0, 0x80000000}.
REQ-037 SHALL verify annul_i pulsed 10 cycles into DivOn -> DivFree next edge, ready_o never rises, and a new start on the following cycle completes 200/10 -> {0, 20}.
REQ-038 SHALL verify that holding start_i high after ready_o keeps result_o stable for 5 cycles, and dropping start_i -> ready_o=0 and result_o=0 next edge.
REQ-039 SHALL verify rst asserted mid-DivOn -> all outputs 0 on the next edge, and a fresh 9/3 completes to {0, 3} after 34 cycles.
